// File: rtl/ifetch_unit.sv
// ifetch_unit: in-order fetch stage with a PC-tag queue and a DEPTH-entry decode FIFO.
// Define MISALIGN_TRAP_EN to trap misaligned PCs into the FIFO and add id_exc_o.
module ifetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pc_i,
  output logic        pc_stall_o,
  input  logic        redirect_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        id_exc_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0] outst, drop, cnt;
  logic [CW:0]   used;
  logic [AW-1:0] tq_wr, tq_rd, wr, rd;
  logic [31:0]   tq    [DEPTH];
  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   ins_q [DEPTH];
`ifdef MISALIGN_TRAP_EN
  logic [DEPTH-1:0] exc_q;
`endif
  logic room, mis, acc, xpush, keep, push, pop;
  // outst counts every in-flight request, including those marked for dropping
  always_comb begin
    used = {1'b0, outst} + {1'b0, cnt};
    room = rst_n_i & ~redirect_i & (used < (CW+1)'(DEPTH));
`ifdef MISALIGN_TRAP_EN
    mis = |pc_i[1:0];
    imem_req_addr_o = pc_i;
`else
    mis = 1'b0;
    imem_req_addr_o = {pc_i[31:2], 2'b00};
`endif
    imem_req_valid_o = room & ~mis;
    acc = imem_req_valid_o & imem_req_ready_i;
    xpush = room & mis & ~|outst;
    pc_stall_o = ~(acc | xpush | (rst_n_i & redirect_i));
    keep = imem_rsp_valid_i & ~redirect_i & ~|drop;
    push = xpush | keep;
    id_valid_o = |cnt;
    pop = id_valid_o & id_ready_i & ~redirect_i;
    id_pc_o = id_valid_o ? pc_q[rd] : '0;
    id_instr_o = id_valid_o ? ins_q[rd] : NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
    id_exc_o = id_valid_o & exc_q[rd];
`endif
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outst <= '0;
      drop  <= '0;
      cnt   <= '0;
      tq_wr <= '0;
      tq_rd <= '0;
      wr    <= '0;
      rd    <= '0;
    end else begin
      if (acc) tq_wr <= tq_wr + AW'(1);
      if (imem_rsp_valid_i) tq_rd <= tq_rd + AW'(1);
      outst <= outst + CW'(acc) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
        drop <= outst - CW'(imem_rsp_valid_i);
        cnt  <= '0;
        wr   <= '0;
        rd   <= '0;
      end else begin
        if (imem_rsp_valid_i && |drop) drop <= drop - CW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
        if (push) wr <= wr + AW'(1);
        if (pop) rd <= rd + AW'(1);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc) tq[tq_wr] <= pc_i;
    if (push && !redirect_i) begin
      pc_q[wr]  <= xpush ? pc_i : tq[tq_rd];
      ins_q[wr] <= xpush ? NOP_INSTR : imem_rsp_data_i;
`ifdef MISALIGN_TRAP_EN
      exc_q[wr] <= xpush;
`endif
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: random stimulus against a transaction-level model of the fetch stage.
module tb_ifetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
  logic id_exc_o;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic [31:0] pc_i, imem_req_addr_o, imem_rsp_data_i, id_pc_o, id_instr_o;
  logic pc_stall_o, redirect_i, imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i;
  logic id_valid_o, id_ready_i;
  ifetch_unit #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pc_i(pc_i), .pc_stall_o(pc_stall_o),
    .redirect_i(redirect_i), .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
    .id_instr_o(id_instr_o)
`ifdef MISALIGN_TRAP_EN
    , .id_exc_o(id_exc_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  typedef struct { logic [31:0] pc; logic [31:0] addr; int due; bit drop; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit exc; } ent_t;
  req_t mq[$];
  ent_t vis[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] pc = '0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic idle();
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    id_ready_i = 1'b0;
    pc_i = pc;
  endtask
  task automatic step(input int pr, input int pi, input int pd, input int lat);
    bit room, mis, e_req, e_acc, e_x, e_stall, rsp, redir;
    logic [31:0] tgt, e_addr;
    req_t r;
    ent_t h;
    @(negedge clk_i);
    redir = $urandom_range(99) < pd;
    tgt = $urandom & 32'h0000_FFFC;
    if ($urandom_range(3) == 0) tgt[1:0] = 2'($urandom_range(3));
    rsp = mq.size() != 0 && mq[0].due <= cyc;
    redirect_i = redir;
    imem_req_ready_i = $urandom_range(99) < pr;
    id_ready_i = $urandom_range(99) < pi;
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i = rsp ? mem(mq[0].addr) : $urandom;
    pc_i = pc;
    room = !redir && (mq.size() + vis.size() < DEPTH);
    mis = MIS && pc[1:0] != 2'b00;
    e_req = room && !mis;
    e_acc = e_req && imem_req_ready_i;
    e_x = room && mis && mq.size() == 0;
    e_stall = !(e_acc || e_x || redir);
    e_addr = MIS ? pc : {pc[31:2], 2'b00};
    h = vis.size() != 0 ? vis[0] : '{pc: 32'h0, instr: NOP, exc: 1'b0};
    #1;
    check("req_valid", 32'(imem_req_valid_o), 32'(e_req));
    check("req_addr", imem_req_addr_o, e_addr);
    check("pc_stall", 32'(pc_stall_o), 32'(e_stall));
    check("id_valid", 32'(id_valid_o), 32'(vis.size() != 0));
    check("id_pc", id_pc_o, h.pc);
    check("id_instr", id_instr_o, h.instr);
`ifdef MISALIGN_TRAP_EN
    check("id_exc", 32'(id_exc_o), 32'(h.exc));
`endif
    @(posedge clk_i);
    cyc++;
    if (rsp) r = mq.pop_front();
    if (redir) begin
      vis.delete();
      foreach (mq[i]) mq[i].drop = 1'b1;
    end else begin
      if (vis.size() != 0 && id_ready_i) void'(vis.pop_front());
      if (e_x) vis.push_back('{pc: pc, instr: NOP, exc: 1'b1});
      else if (rsp && !r.drop) vis.push_back('{pc: r.pc, instr: mem(r.addr), exc: 1'b0});
    end
    if (e_acc) mq.push_back('{pc: pc, addr: e_addr, due: cyc + $urandom_range(lat), drop: 1'b0});
    if (!e_stall) pc = redir ? tgt : pc + 32'd4;
  endtask
  initial begin
    idle();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 20 && mq.size() < 2; i++) step(100, 100, 0, 4);
    check("rst_setup_outstanding", 32'(mq.size()), 32'd2);
    @(negedge clk_i);
    idle();
    rst_n_i = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rst_id_valid", 32'(id_valid_o), 32'd0);
    check("rst_id_instr", id_instr_o, NOP);
    check("rst_id_pc", id_pc_o, 32'd0);
    check("rst_pc_stall", 32'(pc_stall_o), 32'd1);
    mq.delete();
    vis.delete();
    pc = 32'h0000_0010;
    @(posedge clk_i);
    @(negedge clk_i);
    pc_i = pc;
    rst_n_i = 1'b1;
    repeat (30) step(100, 100, 0, 0);
    repeat (12) step(100, 0, 0, 1);
    repeat (6) step(100, 100, 0, 0);
    repeat (6) step(0, 100, 0, 1);
    repeat (6) step(100, 100, 0, 1);
    repeat (20) step(100, 100, 15, 2);
    for (int i = 0; i < 40; i++) begin
      int pr, pi, pd, lat;
      pr = $urandom_range(20, 100);
      pi = $urandom_range(10, 100);
      pd = $urandom_range(0, 12);
      lat = $urandom_range(0, 4);
      repeat (50) step(pr, pi, pd, lat);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
